txrx_buf: RTL and testbench

Parametrised, buffered CPU front-end for the radio transmitter/receiver cores. Replaces the single-register TX/RX access path with configurable-depth byte FIFOs on both directions, a channel-count-checked channel register, a CRC-good packet counter and a maskable interrupt. It sits between the SoC native bus and the `tx`/`rx` byte streams.

---
 rtl/txrx_buf.sv | 202 ++++++++++++++++++++
 tb/tb_txrx_buf.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/txrx_buf.sv
// Buffered CPU front-end for the radio TX/RX byte streams: byte FIFOs both ways,
// channel/access-address registers, CRC-good packet counter. Optional IRQ block: TXRX_IRQ_EN.

module txrx_fifo #(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       head,
  output logic [LVL_W-1:0] level,
  output logic             empty,
  output logic             full,
  output logic             drop
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  // A pop frees a slot in the same cycle, so a push into a full FIFO is still taken.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

module txrx_buf #(
  parameter int          DEPTH  = 16,
  parameter int          N_CH   = 40,
  parameter int          CH_W   = 6,
  parameter logic [31:0] AA_RST = 32'h8E89BED6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid,
  input  logic [3:0]      address,
  input  logic [31:0]     wdata,
  input  logic            wstrb,
  output logic [31:0]     rdata,
  output logic            ready,
  output logic            tx_start,
  output logic [7:0]      tx_byte,
  output logic            tx_byte_valid,
  input  logic            tx_byte_ready,
  input  logic [7:0]      rx_byte,
  input  logic            rx_byte_valid,
  input  logic            rx_pkt_end,
  input  logic            rx_crc_ok,
  output logic [31:0]     aa,
  output logic [CH_W-1:0] ch_idx,
  output logic            irq
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             act, act_wr, act_rd;
  logic             tx_en, rx_en, tx_ovf, rx_ovf;
  logic [15:0]      pkt_cnt;
  logic             pkt_good, pkt_clr;
  logic [31:0]      rd_mux;
  logic [7:0]       tx_head, rx_head;
  logic [LVL_W-1:0] tx_level, rx_level;
  logic             tx_empty, tx_full, tx_drop, tx_push, tx_pop, tx_flush;
  logic             rx_empty, rx_full, rx_drop, rx_push, rx_pop, rx_flush;

  // A request acts once, in the cycle before its registered ready.
  assign act      = valid & ~ready;
  assign act_wr   = act & wstrb;
  assign act_rd   = act & ~wstrb;

  assign tx_push  = act_wr && (address == 4'd1);
  assign tx_flush = act_wr && (address == 4'd0) && wdata[2];
  assign tx_byte_valid = tx_en & ~tx_empty;
  assign tx_pop   = tx_byte_valid & tx_byte_ready;
  assign tx_byte  = tx_empty ? 8'h00 : tx_head;

  assign rx_push  = rx_en & rx_byte_valid;
  assign rx_pop   = act_rd && (address == 4'd2);
  assign rx_flush = act_wr && (address == 4'd0) && wdata[3];

  assign pkt_good = rx_pkt_end & rx_crc_ok;
  assign pkt_clr  = act_wr && (address == 4'd6);

  txrx_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .flush(tx_flush), .push(tx_push), .pop(tx_pop),
    .din(wdata[7:0]), .head(tx_head), .level(tx_level), .empty(tx_empty),
    .full(tx_full), .drop(tx_drop)
  );

  txrx_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .flush(rx_flush), .push(rx_push), .pop(rx_pop),
    .din(rx_byte), .head(rx_head), .level(rx_level), .empty(rx_empty),
    .full(rx_full), .drop(rx_drop)
  );

`ifdef TXRX_IRQ_EN
  logic [3:0] irq_mask, irq_pend, irq_ev, irq_clr;
  logic       tx_empty_q, irq_q;

  assign irq_ev  = {tx_drop | rx_drop, tx_empty & ~tx_empty_q,
                    rx_level >= LVL_W'(DEPTH / 2), pkt_good};
  assign irq_clr = (act_wr && (address == 4'd8)) ? wdata[3:0] : 4'h0;
  assign irq     = irq_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_mask   <= '0;
      irq_pend   <= '0;
      tx_empty_q <= 1'b1;
      irq_q      <= 1'b0;
    end else begin
      tx_empty_q <= tx_empty;
      irq_q      <= |(irq_pend & irq_mask);
      irq_pend   <= (irq_pend & ~irq_clr) | irq_ev;
      if (act_wr && (address == 4'd7)) irq_mask <= wdata[3:0];
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_mux = 32'hFFFF_FFFF;
    case (address)
      4'd0: rd_mux = {30'b0, rx_en, tx_en};
      4'd1: rd_mux = 32'h0;
      4'd2: rd_mux = rx_empty ? 32'h0 : {24'b0, rx_head};
      4'd3: rd_mux = {8'h00, 8'(rx_level), 8'(tx_level), 2'b00, tx_ovf, rx_ovf,
                      rx_full, rx_empty, tx_full, tx_empty};
      4'd4: rd_mux = aa;
      4'd5: rd_mux = 32'(ch_idx);
      4'd6: rd_mux = {16'h0, pkt_cnt};
`ifdef TXRX_IRQ_EN
      4'd7: rd_mux = {28'b0, irq_mask};
      4'd8: rd_mux = {28'b0, irq_pend};
`else
      4'd7: rd_mux = 32'h0;
      4'd8: rd_mux = 32'h0;
`endif
      default: rd_mux = 32'hFFFF_FFFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready    <= 1'b0;
      rdata    <= '0;
      tx_start <= 1'b0;
      tx_en    <= 1'b0;
      rx_en    <= 1'b0;
      aa       <= AA_RST;
      ch_idx   <= CH_W'(5);
      tx_ovf   <= 1'b0;
      rx_ovf   <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      ready    <= act;
      tx_start <= act_wr && (address == 4'd0) && wdata[4];
      if (act) rdata <= rd_mux;
      if (act_wr) begin
        case (address)
          4'd0: {rx_en, tx_en} <= wdata[1:0];
          4'd4: aa <= wdata;
          4'd5: if (wdata < 32'(N_CH)) ch_idx <= wdata[CH_W-1:0];
          default: ;
        endcase
      end
      // A new overflow in the clearing cycle wins over the clear.
      if (act_wr && (address == 4'd3)) begin
        tx_ovf <= 1'b0;
        rx_ovf <= 1'b0;
      end
      if (tx_drop) tx_ovf <= 1'b1;
      if (rx_drop) rx_ovf <= 1'b1;
      if (pkt_good)     pkt_cnt <= pkt_clr ? 16'd1 : pkt_cnt + 16'd1;
      else if (pkt_clr) pkt_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_txrx_buf.sv
// Directed self-checking bench for txrx_buf (default parameters); IRQ checks follow TXRX_IRQ_EN.
`timescale 1ns/1ps
module tb_txrx_buf;
  logic        clk = 1'b0;
  logic        rst_n, valid, wstrb, tx_byte_ready, rx_byte_valid, rx_pkt_end, rx_crc_ok;
  logic [3:0]  address;
  logic [31:0] wdata, rdata, aa;
  logic        ready, tx_start, tx_byte_valid, irq;
  logic [7:0]  tx_byte, rx_byte;
  logic [5:0]  ch_idx;
  int          n_tests = 0;
  int          n_fail  = 0;

  txrx_buf dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .address(address), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .tx_start(tx_start),
    .tx_byte(tx_byte), .tx_byte_valid(tx_byte_valid), .tx_byte_ready(tx_byte_ready),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .rx_pkt_end(rx_pkt_end),
    .rx_crc_ok(rx_crc_ok), .aa(aa), .ch_idx(ch_idx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk); valid = 1'b1; address = a; wdata = d; wstrb = 1'b1;
    @(negedge clk); valid = 1'b0; wstrb = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk); valid = 1'b1; address = a; wstrb = 1'b0;
    @(negedge clk); valid = 1'b0;
    chk({tag, " ready"}, 32'(ready), 32'd1);
    chk(tag, rdata, exp);
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(negedge clk); rx_byte = b; rx_byte_valid = 1'b1;
    @(negedge clk); rx_byte_valid = 1'b0;
  endtask

  task automatic pkt(input logic crc);
    @(negedge clk); rx_pkt_end = 1'b1; rx_crc_ok = crc;
    @(negedge clk); rx_pkt_end = 1'b0; rx_crc_ok = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; valid = 1'b0; wstrb = 1'b0; address = '0; wdata = '0;
    tx_byte_ready = 1'b0; rx_byte = '0; rx_byte_valid = 1'b0;
    rx_pkt_end = 1'b0; rx_crc_ok = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst ready", 32'(ready), 32'd0);
    chk("rst tx_start", 32'(tx_start), 32'd0);
    chk("rst tx_byte_valid", 32'(tx_byte_valid), 32'd0);
    chk("rst tx_byte", 32'(tx_byte), 32'd0);
    chk("rst irq", 32'(irq), 32'd0);
    chk("rst aa port", aa, 32'h8E89BED6);
    chk("rst ch_idx port", 32'(ch_idx), 32'd5);
    rd_chk("rst CTRL", 4'd0, 32'h0);
    rd_chk("rst RX_DATA empty", 4'd2, 32'h0);
    rd_chk("rst STATUS", 4'd3, 32'h5);
    rd_chk("rst AA", 4'd4, 32'h8E89BED6);
    rd_chk("rst CH_IDX", 4'd5, 32'd5);
    rd_chk("rst PKT_CNT", 4'd6, 32'h0);
    rd_chk("rst IRQ_MASK", 4'd7, 32'h0);
    rd_chk("rst IRQ_PEND", 4'd8, 32'h0);
    rd_chk("unmapped", 4'd9, 32'hFFFF_FFFF);

    // TX fill past full with tx_en low, then drain in order
    for (int i = 1; i <= 17; i++) bus_wr(4'd1, 32'(i));
    rd_chk("tx full status", 4'd3, 32'h0000_1026);
    tx_byte_ready = 1'b1;
    bus_wr(4'd0, 32'h1);
    for (int k = 0; k < 16; k++) begin
      chk("tx drain valid", 32'(tx_byte_valid), 32'd1);
      chk("tx drain byte", 32'(tx_byte), 32'(k + 1));
      @(negedge clk);
    end
    chk("tx drained valid", 32'(tx_byte_valid), 32'd0);
    tx_byte_ready = 1'b0;
    bus_wr(4'd0, 32'h11);
    chk("tx_start pulse", 32'(tx_start), 32'd1);
    @(negedge clk);
    chk("tx_start end", 32'(tx_start), 32'd0);
    rd_chk("tx_ovf sticky", 4'd3, 32'h25);
    bus_wr(4'd3, 32'h0);
    rd_chk("sticky cleared", 4'd3, 32'h5);

    // RX full, simultaneous push+pop, overflow, drain
    bus_wr(4'd0, 32'h3);
    for (int i = 0; i < 16; i++) rx_push(8'hA0 + 8'(i));
    rd_chk("rx full status", 4'd3, 32'h0010_0009);
    @(negedge clk); valid = 1'b1; address = 4'd2; wstrb = 1'b0; rx_byte = 8'hC0; rx_byte_valid = 1'b1;
    @(negedge clk); valid = 1'b0; rx_byte_valid = 1'b0;
    chk("rx pushpop data", rdata, 32'hA0);
    rd_chk("rx pushpop status", 4'd3, 32'h0010_0009);
    rx_push(8'hD0);
    rd_chk("rx ovf status", 4'd3, 32'h0010_0019);
    for (int i = 1; i < 16; i++) rd_chk("rx drain", 4'd2, 32'hA0 + 32'(i));
    rd_chk("rx drain last", 4'd2, 32'hC0);
    rd_chk("rx empty read", 4'd2, 32'h0);
    rd_chk("rx drained status", 4'd3, 32'h15);
    bus_wr(4'd3, 32'hFFFF_FFFF);
    rx_push(8'h11);
    rx_push(8'h22);
    rd_chk("rx two status", 4'd3, 32'h0002_0001);
    bus_wr(4'd0, 32'hB);
    rd_chk("rx flush status", 4'd3, 32'h5);
    rd_chk("ctrl readback", 4'd0, 32'h3);
    bus_wr(4'd0, 32'h1);
    rx_push(8'h55);
    rd_chk("rx disabled", 4'd3, 32'h5);

    // Channel index bounds
    bus_wr(4'd5, 32'd40);
    rd_chk("ch 40 ignored", 4'd5, 32'd5);
    bus_wr(4'd5, 32'd39);
    rd_chk("ch 39", 4'd5, 32'd39);
    chk("ch port", 32'(ch_idx), 32'd39);
    bus_wr(4'd4, 32'h1234_5678);
    rd_chk("aa write", 4'd4, 32'h1234_5678);

    // Packet counter wrap, CRC-bad, increment vs clear
    @(negedge clk); rx_pkt_end = 1'b1; rx_crc_ok = 1'b1;
    repeat (65535) @(negedge clk);
    rx_pkt_end = 1'b0; rx_crc_ok = 1'b0;
    rd_chk("pkt ffff", 4'd6, 32'hFFFF);
    pkt(1'b1);
    rd_chk("pkt wrap", 4'd6, 32'h0);
    pkt(1'b0);
    rd_chk("pkt crc bad", 4'd6, 32'h0);
    @(negedge clk); valid = 1'b1; address = 4'd6; wdata = 32'h0; wstrb = 1'b1;
    rx_pkt_end = 1'b1; rx_crc_ok = 1'b1;
    @(negedge clk); valid = 1'b0; wstrb = 1'b0; rx_pkt_end = 1'b0; rx_crc_ok = 1'b0;
    rd_chk("pkt inc beats clear", 4'd6, 32'h1);
    bus_wr(4'd6, 32'h0);
    rd_chk("pkt clear", 4'd6, 32'h0);

`ifdef TXRX_IRQ_EN
    bus_wr(4'd8, 32'hF);
    bus_wr(4'd7, 32'h1);
    rd_chk("irq mask", 4'd7, 32'h1);
    chk("irq idle", 32'(irq), 32'd0);
    pkt(1'b1);
    chk("irq +1", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq +2", 32'(irq), 32'd1);
    rd_chk("irq pend", 4'd8, 32'h1);
    bus_wr(4'd8, 32'h1);
    @(negedge clk);
    chk("irq after w1c", 32'(irq), 32'd0);
    rd_chk("irq pend cleared", 4'd8, 32'h0);
`else
    bus_wr(4'd7, 32'hF);
    bus_wr(4'd8, 32'hF);
    rd_chk("no-irq mask", 4'd7, 32'h0);
    rd_chk("no-irq pend", 4'd8, 32'h0);
    pkt(1'b1);
    @(negedge clk);
    chk("no-irq irq", 32'(irq), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
